swing_arbiter: RTL
==================

Name: swing_arbiter

Overview:
- Shares one `sultans_of_swing` unit among NUM_REQ requesters. The unit is a 1-cycle registered stage: Ao=Ai, Bo=Bi, ANDo=(Ai^Bi)&Ci.
- Round-robin arbitration with a per-requester req/gnt handshake.
- The block tags each issued operation with the requester index and returns the result through a valid/ready output register.
- It instantiates the unit internally and sits between the nonce/work requesters and the downstream collector.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester tag; must satisfy 2**ID_W >= NUM_REQ.
- DATA_W, 4, operand width; fixed to 4 to match `sultans_of_swing`.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; also drives the unit's reset.
- req  in  NUM_REQ  request bit per requester; held until granted.
- req_A  in  NUM_REQ*DATA_W  packed A operands; requester i uses [i*4+:4].
- req_B  in  NUM_REQ*DATA_W  packed B operands.
- req_C  in  NUM_REQ*DATA_W  packed C operands.
- gnt  out  NUM_REQ  one-hot, combinational; gnt[i]=1 means requester i's operands are accepted this cycle.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  downstream accepts the result when out_valid & out_ready.
- out_id  out  ID_W  requester index of the result.
- out_A  out  DATA_W  unit Ao for that operation.
- out_B  out  DATA_W  unit Bo for that operation.
- out_AND  out  DATA_W  unit ANDo for that operation.
- busy  out  1  high when any operation is in flight or out_valid=1.

Behaviour:
- Reset (synchronous, sampled at posedge while reset=1):
  - out_valid=0, out_id=0, out_A/out_B/out_AND=0, rr_ptr=0.
  - In-flight tag cleared (iss_valid_q=0, iss_id_q=0); operand hold register cleared.
  - gnt=0 combinationally while reset=1.
  - Reset mid-operation discards all in-flight and pending results; no result is ever emitted for a pre-reset grant.
- Stall: stall = out_valid & ~out_ready.
- Arbitration (combinational, each cycle):
  - When ~stall and ~reset: grant the first requester with req=1, searching from rr_ptr upward with wrap-around (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - When stall, or no req: gnt=0.
- Issue:
  - On a grant to i, the unit inputs are requester i's operands.
  - At the posedge: iss_valid_q<=1, iss_id_q<=i, hold register <= those operands, rr_ptr <= (i+1) mod NUM_REQ.
  - No grant and ~stall: unit inputs = hold register (don't-care value), iss_valid_q<=0, rr_ptr unchanged.
- Stall hold:
  - When stall, the unit inputs are driven from the hold register, so unit outputs stay stable.
  - iss_valid_q, iss_id_q and rr_ptr are unchanged.
  - No result is lost or duplicated.
- Result capture: at a posedge with ~stall:
  - out_valid <= iss_valid_q.
  - If iss_valid_q: out_id/out_A/out_B/out_AND <= iss_id_q and the unit outputs.
  - Otherwise the data fields are held.
- Handshake:
  - out_valid rising with out_ready=0 holds out_id and all data stable until accepted.
  - out_valid & out_ready with a new result arriving in the same cycle gives back-to-back valid results (no bubble).
- Latency and throughput:
  - Grant in cycle T gives out_valid=1 in cycle T+2.
  - Sustained throughput is 1 operation/cycle when out_ready=1.
- Ordering: results leave in grant order. At most 2 operations are in flight (unit stage + output register).
- Fairness: a requester holding req=1 is granted within NUM_REQ grant cycles.
- busy = iss_valid_q | out_valid.
- A single requester with req held high is granted every non-stalled cycle.

Test Plan:
- Reset, then all req=0 → gnt=0, out_valid=0, busy=0, out_* =0 for 5 cycles.
- req[0] only, A=0011 B=0110 C=0001, one cycle, out_ready=1 → gnt=0001 at T; at T+2 out_valid=1, out_id=0, out_A=0011, out_B=0110, out_AND=0001.
- req=1111 held, out_ready=1, operands:
  - r0: 0011/0110/0001
  - r1: 1011/0111/1100
  - r2: 1001/0111/0000
  - r3: 1111/0000/0110
  - Required: gnt sequence 0001,0010,0100,1000,0001; results id 0,1,2,3 with out_AND 0001,1100,0000,0110 on consecutive cycles.
- Repeat the previous scenario with out_ready=0 for 3 cycles after the first out_valid:
  - gnt=0 during the stall; out_id=0 and out_AND=0001 held stable.
  - After release, ids 1,2,3 follow with no loss or duplicate.
- req[2] and req[3] both high with rr_ptr=3 → gnt=1000 first, then 0100; rr_ptr wraps to 0 after the grant to 3.
- Assert reset for one cycle while 2 operations are in flight → out_valid=0, busy=0, rr_ptr=0 next cycle; no stale result appears afterwards.

Source files
------------

// File: rtl/swing_arbiter.sv
// Round-robin front end sharing one sultans_of_swing stage.
// Results return in grant order through a valid/ready output register.
module sultans_of_swing (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Ai,
  input  logic [3:0] Bi,
  input  logic [3:0] Ci,
  output logic [3:0] Ao,
  output logic [3:0] Bo,
  output logic [3:0] ANDo
);
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] and_q, and_d;

  always_comb begin
    a_d   = Ai;
    b_d   = Bi;
    and_d = (Ai ^ Bi) & Ci;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      and_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      and_q <= and_d;
    end
  end

  assign Ao   = a_q;
  assign Bo   = b_q;
  assign ANDo = and_q;
endmodule

module swing_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_A,
  input  logic [NUM_REQ*DATA_W-1:0] req_B,
  input  logic [NUM_REQ*DATA_W-1:0] req_C,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ID_W-1:0]           out_id,
  output logic [DATA_W-1:0]         out_A,
  output logic [DATA_W-1:0]         out_B,
  output logic [DATA_W-1:0]         out_AND,
  output logic                      busy
);
  logic              stall;
  logic              grant;
  logic [ID_W-1:0]   gnt_idx;
  int                j;

  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              iss_valid_q, iss_valid_d;
  logic [ID_W-1:0]   iss_id_q, iss_id_d;
  logic [DATA_W-1:0] hold_a_q, hold_a_d;
  logic [DATA_W-1:0] hold_b_q, hold_b_d;
  logic [DATA_W-1:0] hold_c_q, hold_c_d;
  logic              out_valid_q, out_valid_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic [DATA_W-1:0] out_a_q, out_a_d;
  logic [DATA_W-1:0] out_b_q, out_b_d;
  logic [DATA_W-1:0] out_and_q, out_and_d;

  logic [DATA_W-1:0] u_ai, u_bi, u_ci;
  logic [DATA_W-1:0] u_ao, u_bo, u_ando;

  assign stall = out_valid_q & ~out_ready;

  // Search from rr_ptr upward, wrapping, for the first pending request.
  always_comb begin
    grant    = 1'b0;
    gnt      = '0;
    gnt_idx  = '0;
    rr_ptr_d = rr_ptr_q;
    j        = 0;
    if (!reset && !stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = int'(rr_ptr_q) + k;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        if (!grant && req[j]) begin
          grant   = 1'b1;
          gnt[j]  = 1'b1;
          gnt_idx = ID_W'(j);
          rr_ptr_d = (j == NUM_REQ - 1) ? '0 : ID_W'(j + 1);
        end
      end
    end
  end

  always_comb begin
    u_ai = hold_a_q;
    u_bi = hold_b_q;
    u_ci = hold_c_q;
    if (grant) begin
      u_ai = req_A[gnt_idx*DATA_W +: DATA_W];
      u_bi = req_B[gnt_idx*DATA_W +: DATA_W];
      u_ci = req_C[gnt_idx*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_id_d    = iss_id_q;
    hold_a_d    = hold_a_q;
    hold_b_d    = hold_b_q;
    hold_c_d    = hold_c_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_and_d   = out_and_q;
    if (!stall) begin
      iss_valid_d = grant;
      if (grant) begin
        iss_id_d = gnt_idx;
        hold_a_d = u_ai;
        hold_b_d = u_bi;
        hold_c_d = u_ci;
      end
      out_valid_d = iss_valid_q;
      if (iss_valid_q) begin
        out_id_d  = iss_id_q;
        out_a_d   = u_ao;
        out_b_d   = u_bo;
        out_and_d = u_ando;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      iss_valid_q <= 1'b0;
      iss_id_q    <= '0;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
      hold_c_q    <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_and_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      iss_valid_q <= iss_valid_d;
      iss_id_q    <= iss_id_d;
      hold_a_q    <= hold_a_d;
      hold_b_q    <= hold_b_d;
      hold_c_q    <= hold_c_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_and_q   <= out_and_d;
    end
  end

  sultans_of_swing u_sos (
    .clk   (clk),
    .reset (reset),
    .Ai    (u_ai),
    .Bi    (u_bi),
    .Ci    (u_ci),
    .Ao    (u_ao),
    .Bo    (u_bo),
    .ANDo  (u_ando)
  );

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_A     = out_a_q;
  assign out_B     = out_b_q;
  assign out_AND   = out_and_q;
  assign busy      = iss_valid_q | out_valid_q;
endmodule
